// File: rtl/ternary_fetch_sequencer.sv
// Dual-bank SRAM read sequencer: sweeps both read ports in lockstep, absorbs the
// 1-cycle read latency and streams aligned {weight, input} pairs through a small FIFO.
module ternary_fetch_sequencer #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 24,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base_a,
    input  logic [ADDR_WIDTH-1:0] cmd_base_b,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] sram_dout_a,
    input  logic [DATA_WIDTH-1:0] sram_dout_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_weight,
    output logic [DATA_WIDTH-1:0] out_input,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PAIR_W = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic [LEN_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  done_q, done_d;
    logic [PAIR_W-1:0]     fifo_mem_q [FIFO_DEPTH];
    logic [PAIR_W-1:0]     fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      fifo_count_q, fifo_count_d;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [CNT_W:0]        credit_used;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push       = inflight_q;
    assign out_valid  = (fifo_count_q != '0);
    assign pop        = out_valid & out_ready;
    assign out_weight = fifo_mem_q[rd_ptr_q][PAIR_W-1:DATA_WIDTH];
    assign out_input  = fifo_mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign out_last   = out_valid & (pop_cnt_q == LEN_WIDTH'(1));
    assign addr_a     = addr_a_q;
    assign addr_b     = addr_b_q;
    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

    // Credit counts a slot as taken from issue until pop, so a read never lands on a full FIFO.
    assign credit_used = {1'b0, fifo_count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);

    always_comb begin
        state_d     = state_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        issue_cnt_d = issue_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        done_d      = 1'b0;
        issue       = 1'b0;

        if (pop) begin
            pop_cnt_d = pop_cnt_q - LEN_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_a_d    = cmd_base_a;
                    addr_b_d    = cmd_base_b;
                    issue_cnt_d = cmd_len;
                    pop_cnt_d   = cmd_len;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (credit_used < (CNT_W+1)'(FIFO_DEPTH)) begin
                    issue       = 1'b1;
                    addr_a_d    = addr_a_q + ADDR_WIDTH'(1);
                    addr_b_d    = addr_b_q + ADDR_WIDTH'(1);
                    issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
                    if (issue_cnt_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && (pop_cnt_q == LEN_WIDTH'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        inflight_d = issue;
    end

    always_comb begin
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {sram_dout_a, sram_dout_b};
            wr_ptr_d             = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            issue_cnt_q  <= '0;
            pop_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            issue_cnt_q  <= issue_cnt_d;
            pop_cnt_q    <= pop_cnt_d;
            inflight_q   <= inflight_d;
            done_q       <= done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            fifo_mem_q   <= fifo_mem_d;
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (fifo_count_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_ternary_fetch_sequencer.sv
// Bench for ternary_fetch_sequencer: SRAM banks modelled as arrays, expected beats
// derived from command bases/length and compared beat by beat.
module tb_ternary_fetch_sequencer;
    localparam int AW = 12;
    localparam int DW = 24;
    localparam int LW = 13;
    localparam int BANK = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base_a;
    logic [AW-1:0] cmd_base_b;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] sram_dout_a;
    logic [DW-1:0] sram_dout_b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_weight;
    logic [DW-1:0] out_input;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] bank_a [BANK];
    logic [DW-1:0] bank_b [BANK];
    logic [2*DW-1:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;
    logic [AW-1:0] next_ba;
    logic [AW-1:0] next_bb;
    int            next_len;

    always #5 clk = ~clk;

    ternary_fetch_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base_a(cmd_base_a), .cmd_base_b(cmd_base_b), .cmd_len(cmd_len),
        .addr_a(addr_a), .addr_b(addr_b),
        .sram_dout_a(sram_dout_a), .sram_dout_b(sram_dout_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_weight(out_weight), .out_input(out_input), .out_last(out_last),
        .busy(busy), .done(done)
    );

    // Synchronous-read SRAM: data for an address appears one cycle later.
    always @(posedge clk) begin
        sram_dout_a <= bank_a[addr_a];
        sram_dout_b <= bank_b[addr_b];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic load_exp(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({bank_a[(int'(ba) + i) % BANK], bank_b[(int'(bb) + i) % BANK]});
        end
    endtask

    task automatic check_reset_values();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_addr_a", addr_a, 0);
        chk("rst_addr_b", addr_b, 0);
        chk("rst_out_data", {out_weight, out_input}, 0);
    endtask

    task automatic send_cmd(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input int len);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_base_a = ba;
        cmd_base_b = bb;
        cmd_len    = LW'(len);
        chk("cmd_ready_at_offer", cmd_ready, 1);
        @(posedge clk);
        load_exp(ba, bb, len);
    endtask

    // Called right after the acceptance edge; k counts falling edges after it.
    task automatic run_cmd(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input int len,
                           input int stall_after, input bit rand_ready, input bit hold_valid,
                           input int abort_after);
        int k = 0;
        int beats = 0;
        int last_pop_k = -1;
        int stall_left = 0;
        int stall_idx = 0;
        bit done_seen = 0;
        bit prev_hold = 0;
        bit first_seen = 0;
        bit exp_done;
        bit exp_rdy;
        logic [2*DW-1:0] prev_data = '0;
        logic [AW-1:0] frz_a = '0;
        logic [AW-1:0] frz_b = '0;
        while (!done_seen && k < 400) begin
            @(negedge clk);
            if (k == 0) begin
                if (hold_valid) begin
                    cmd_base_a = next_ba;
                    cmd_base_b = next_bb;
                    cmd_len    = LW'(next_len);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (abort_after > 0 && beats == abort_after) return;
            exp_done = (len == 0) ? (k == 0) : (last_pop_k >= 0 && k == last_pop_k + 1);
            exp_rdy  = (len == 0) ? 1'b1 : exp_done;
            chk("done", done, exp_done);
            chk("cmd_ready", cmd_ready, exp_rdy);
            chk("busy", busy, !exp_rdy);
            if (prev_hold) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", {out_weight, out_input}, prev_data);
            end
            if (out_valid && !first_seen) begin
                first_seen = 1;
                chk("first_beat_latency", k, 2);
            end
            if (out_valid && exp_q.size() == 0) chk("spurious_beat", 1, 0);
            chk("out_last", out_last, out_valid && exp_q.size() == 1);
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                stall_idx++;
                if (stall_idx == 2) begin
                    frz_a = addr_a;
                    frz_b = addr_b;
                end else if (stall_idx > 2) begin
                    chk("addr_a_frozen", addr_a, frz_a);
                    chk("addr_b_frozen", addr_b, frz_b);
                end
            end else begin
                out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                chk("beat_data", {out_weight, out_input}, exp_q.pop_front());
                beats++;
                if (exp_q.size() == 0) last_pop_k = k;
                if (beats == stall_after) stall_left = 5;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = {out_weight, out_input};
            if (exp_done) done_seen = 1;
            k++;
        end
        out_ready = 1'b1;
        if (!done_seen) begin
            chk("timeout_waiting_done", 0, 1);
        end else begin
            chk("end_addr_a", addr_a, (int'(ba) + len) % BANK);
            chk("end_addr_b", addr_b, (int'(bb) + len) % BANK);
            chk("all_beats_delivered", exp_q.size(), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < BANK; i++) begin
            bank_a[i] = DW'($urandom);
            bank_b[i] = DW'($urandom);
        end
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_base_a = '0;
        cmd_base_b = '0;
        cmd_len    = '0;
        out_ready  = 1'b1;
        next_ba    = '0;
        next_bb    = '0;
        next_len   = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        // Basic 4-beat sweep, no backpressure.
        send_cmd(12'h010, 12'h200, 4);
        run_cmd(12'h010, 12'h200, 4, 0, 0, 0, 0);

        // 8 beats with a 5-cycle stall after beat 2.
        send_cmd(12'h123, 12'h456, 8);
        run_cmd(12'h123, 12'h456, 8, 2, 0, 0, 0);

        // Address wrap on bank A.
        send_cmd(12'hFFE, 12'h001, 4);
        run_cmd(12'hFFE, 12'h001, 4, 0, 0, 0, 0);

        // Zero-length command.
        send_cmd(12'h055, 12'h066, 0);
        run_cmd(12'h055, 12'h066, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("len0_done_single", done, 0);
        chk("len0_no_valid", out_valid, 0);
        chk("len0_cmd_ready", cmd_ready, 1);

        // Reset in the middle of a 6-beat command, then a fresh 2-beat command.
        send_cmd(12'h300, 12'h700, 6);
        run_cmd(12'h300, 12'h700, 6, 0, 0, 0, 3);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", done, 0);
            chk("post_rst_no_valid", out_valid, 0);
        end
        send_cmd(12'h040, 12'h080, 2);
        run_cmd(12'h040, 12'h080, 2, 0, 0, 0, 0);

        // cmd_valid held with different fields while a 5-beat command runs.
        next_ba  = 12'hAAA;
        next_bb  = 12'hBBB;
        next_len = 3;
        send_cmd(12'h500, 12'h600, 5);
        run_cmd(12'h500, 12'h600, 5, 0, 0, 1, 0);
        @(posedge clk);
        load_exp(next_ba, next_bb, next_len);
        run_cmd(next_ba, next_bb, next_len, 0, 0, 0, 0);

        // Randomized commands with random backpressure.
        for (int t = 0; t < 8; t++) begin
            logic [AW-1:0] ra;
            logic [AW-1:0] rb;
            int rl;
            ra = AW'($urandom_range(0, BANK - 1));
            rb = AW'($urandom_range(0, BANK - 1));
            rl = $urandom_range(0, 12);
            send_cmd(ra, rb, rl);
            run_cmd(ra, rb, rl, 0, 1, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
